// File: rtl/pep_mmacc_modsw_rx_buffer.sv
// FWFT buffer capturing the push-only modulus-switch stream for the MMACC, with stream-integrity checks.
// Push lands on the registered head one edge later; no upstream backpressure, full without pop drops and flags error[0].
module pep_mmacc_modsw_rx_buffer #(
  parameter int R         = 2,
  parameter int PSI       = 8,
  parameter int MOD_Q_W   = 64,
  parameter int BPBS_ID_W = 4,
  parameter int DEPTH     = 8
) (
  input  logic                         clk,
  input  logic                         a_rst,
  input  logic [PSI*R-1:0]             in_data_avail,
  input  logic                         in_ctrl_avail,
  input  logic [PSI*R*MOD_Q_W-1:0]     in_data,
  input  logic                         in_sob,
  input  logic                         in_eob,
  input  logic                         in_sol,
  input  logic                         in_eol,
  input  logic                         in_sog,
  input  logic                         in_eog,
  input  logic [BPBS_ID_W-1:0]         in_pbs_id,
  output logic                         out_vld,
  input  logic                         out_rdy,
  output logic [PSI*R*MOD_Q_W-1:0]     out_data,
  output logic                         out_sob,
  output logic                         out_eob,
  output logic                         out_sol,
  output logic                         out_eol,
  output logic                         out_sog,
  output logic                         out_eog,
  output logic [BPBS_ID_W-1:0]         out_pbs_id,
  output logic [$clog2(DEPTH):0]       fill_level,
  output logic [3:0]                   error
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int DATA_W = PSI * R * MOD_Q_W;

  localparam logic [0:0] ST_IDLE     = 1'b0;
  localparam logic [0:0] ST_IN_BLOCK = 1'b1;

  typedef struct packed {
    logic [DATA_W-1:0]    data;
    logic                 sob;
    logic                 eob;
    logic                 sol;
    logic                 eol;
    logic                 sog;
    logic                 eog;
    logic [BPBS_ID_W-1:0] pbs_id;
  } entry_t;

  entry_t               mem_q [DEPTH];
  entry_t               in_entry;
  entry_t               head_q, head_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [0:0]           state_q, state_d;
  logic [BPBS_ID_W-1:0] id_q, id_d;
  logic [3:0]           error_q, error_d;

  logic push, pop, full, accept;

  assign in_entry = '{data: in_data, sob: in_sob, eob: in_eob, sol: in_sol, eol: in_eol,
                      sog: in_sog, eog: in_eog, pbs_id: in_pbs_id};

  assign push   = in_ctrl_avail;
  assign pop    = (count_q != '0) & out_rdy;
  assign full   = (count_q == CNT_W'(DEPTH));
  assign accept = push & (~full | pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    head_d   = head_q;
    if (accept) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)    rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({accept, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    // The next head may be the beat being written this very edge; bypass it into the head register.
    if (count_d != '0) begin
      if (accept && (rd_ptr_d == wr_ptr_q)) head_d = in_entry;
      else                                  head_d = mem_q[rd_ptr_d];
    end
  end

  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    error_d  = '0;
    error_d[0] = push & ~accept;
    error_d[1] = ((|in_data_avail) & ~(&in_data_avail)) | (in_data_avail[0] != in_ctrl_avail);
    if (push) begin
      if (in_sob) begin
        // A sob inside a block is reported but still restarts the block with the new id.
        error_d[2] = (state_q == ST_IN_BLOCK);
        id_d       = in_pbs_id;
        state_d    = in_eob ? ST_IDLE : ST_IN_BLOCK;
      end else if (state_q == ST_IDLE) begin
        error_d[2] = 1'b1;
      end else begin
        error_d[3] = (in_pbs_id != id_q);
        if (in_eob) state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      state_q  <= ST_IDLE;
      id_q     <= '0;
      error_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      state_q  <= state_d;
      id_q     <= id_d;
      error_q  <= error_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_ptr_q] <= in_entry;
  end

  assign out_vld    = (count_q != '0);
  assign out_data   = head_q.data;
  assign out_sob    = head_q.sob;
  assign out_eob    = head_q.eob;
  assign out_sol    = head_q.sol;
  assign out_eol    = head_q.eol;
  assign out_sog    = head_q.sog;
  assign out_eog    = head_q.eog;
  assign out_pbs_id = head_q.pbs_id;
  assign fill_level = count_q;
  assign error      = error_q;

endmodule

// File: tb/tb_pep_mmacc_modsw_rx_buffer.sv
// Directed bench for pep_mmacc_modsw_rx_buffer: queue-tracked expected stream plus hand-computed error vectors.
module tb_pep_mmacc_modsw_rx_buffer;

  localparam int R = 2, PSI = 8, W = 64, IDW = 4, DEPTH = 8;
  localparam int NC = PSI * R;
  localparam int DW = NC * W;

  logic            clk = 1'b0;
  logic            a_rst;
  logic [NC-1:0]   in_data_avail;
  logic            in_ctrl_avail;
  logic [DW-1:0]   in_data;
  logic            in_sob, in_eob, in_sol, in_eol, in_sog, in_eog;
  logic [IDW-1:0]  in_pbs_id;
  logic            out_vld;
  logic            out_rdy;
  logic [DW-1:0]   out_data;
  logic            out_sob, out_eob, out_sol, out_eol, out_sog, out_eog;
  logic [IDW-1:0]  out_pbs_id;
  logic [3:0]      fill_level;
  logic [3:0]      error;

  pep_mmacc_modsw_rx_buffer #(.R(R), .PSI(PSI), .MOD_Q_W(W), .BPBS_ID_W(IDW), .DEPTH(DEPTH)) dut (
    .clk(clk), .a_rst(a_rst),
    .in_data_avail(in_data_avail), .in_ctrl_avail(in_ctrl_avail), .in_data(in_data),
    .in_sob(in_sob), .in_eob(in_eob), .in_sol(in_sol), .in_eol(in_eol), .in_sog(in_sog), .in_eog(in_eog),
    .in_pbs_id(in_pbs_id),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data),
    .out_sob(out_sob), .out_eob(out_eob), .out_sol(out_sol), .out_eol(out_eol), .out_sog(out_sog), .out_eog(out_eog),
    .out_pbs_id(out_pbs_id), .fill_level(fill_level), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0]    seed;
    logic           sob;
    logic           eob;
    logic [IDW-1:0] id;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] mk_data(input logic [31:0] seed);
    logic [DW-1:0] d;
    for (int k = 0; k < NC; k++) d[k*W +: W] = {seed, 32'hA5A5_0000 | 32'(k)};
    return d;
  endfunction

  task automatic check_head(input exp_t e);
    logic [DW-1:0] ed;
    ed = mk_data(e.seed);
    chk("head_vld", out_vld, 1);
    chk("head_coef0", out_data[W-1:0], ed[W-1:0]);
    chk("head_data_all", 64'(out_data === ed), 1);
    chk("head_flags", {out_sob, out_eob, out_sol, out_eol, out_sog, out_eog},
        {e.sob, e.eob, e.seed[0], e.seed[1], e.seed[2], e.seed[3]});
    chk("head_id", out_pbs_id, e.id);
  endtask

  // Drives one cycle of inputs, checks the head before the edge, then level/valid/error after it.
  task automatic step(input bit push, input logic [NC-1:0] av, input logic [31:0] seed,
                      input bit sob, input bit eob, input logic [IDW-1:0] id,
                      input bit rdy, input logic [3:0] exp_err);
    bit   pop, acc;
    exp_t e;
    in_ctrl_avail = push;
    in_data_avail = av;
    in_data       = mk_data(seed);
    in_sob = sob; in_eob = eob;
    in_sol = seed[0]; in_eol = seed[1]; in_sog = seed[2]; in_eog = seed[3];
    in_pbs_id = id;
    out_rdy   = rdy;
    if (q.size() != 0) check_head(q[0]);
    pop = (q.size() != 0) && rdy;
    acc = push && ((q.size() < DEPTH) || pop);
    e   = '{seed: seed, sob: sob, eob: eob, id: id};
    if (pop) void'(q.pop_front());
    if (acc) q.push_back(e);
    @(posedge clk); #1;
    chk("fill", fill_level, q.size());
    chk("vld", out_vld, q.size() != 0);
    chk("err", error, exp_err);
  endtask

  task automatic beat(input logic [31:0] seed, input bit sob, input bit eob,
                      input logic [IDW-1:0] id, input bit rdy, input logic [3:0] exp_err);
    step(1'b1, '1, seed, sob, eob, id, rdy, exp_err);
  endtask

  task automatic idle(input bit rdy, input logic [3:0] exp_err);
    step(1'b0, '0, 32'd0, 1'b0, 1'b0, '0, rdy, exp_err);
  endtask

  initial begin
    a_rst = 1'b1;
    in_ctrl_avail = 1'b0; in_data_avail = '0; in_data = '0;
    in_sob = 0; in_eob = 0; in_sol = 0; in_eol = 0; in_sog = 0; in_eog = 0;
    in_pbs_id = '0; out_rdy = 1'b0;
    #1;
    chk("rst_vld", out_vld, 0);
    chk("rst_fill", fill_level, 0);
    chk("rst_err", error, 0);
    chk("rst_data", out_data[W-1:0], 0);
    chk("rst_id", out_pbs_id, 0);
    #11 a_rst = 1'b0;
    @(posedge clk); #1;

    // Single beat through an empty buffer.
    beat(32'd1, 1, 1, 4'd3, 1, 4'b0000);
    idle(1, 4'b0000);
    chk("hold_id", out_pbs_id, 3);

    // Fill under backpressure, ninth beat overflows.
    for (int i = 0; i < 8; i++) beat(32'd10 + 32'(i), 1, 1, 4'd3, 0, 4'b0000);
    chk("fill_full", fill_level, 8);
    beat(32'd18, 1, 1, 4'd3, 0, 4'b0001);
    chk("fill_after_ovf", fill_level, 8);
    idle(0, 4'b0000);
    for (int i = 0; i < 9; i++) idle(1, 4'b0000);

    // Full with concurrent pop every cycle.
    for (int i = 0; i < 8; i++) beat(32'd20 + 32'(i), 1, 1, 4'd3, 0, 4'b0000);
    for (int i = 0; i < 20; i++) beat(32'd28 + 32'(i), 1, 1, 4'd3, 1, 4'b0000);
    chk("fill_conc", fill_level, 8);
    for (int i = 0; i < 8; i++) idle(1, 4'b0000);
    chk("fill_drained", fill_level, 0);

    // Framing and pbs_id checks.
    beat(32'd50, 1, 0, 4'd2, 1, 4'b0000);
    beat(32'd51, 0, 0, 4'd2, 1, 4'b0000);
    beat(32'd52, 0, 0, 4'd5, 1, 4'b1000);
    beat(32'd53, 0, 1, 4'd2, 1, 4'b0000);
    beat(32'd54, 0, 0, 4'd2, 1, 4'b0100);
    beat(32'd55, 1, 0, 4'd7, 1, 4'b0000);
    beat(32'd56, 1, 0, 4'd7, 1, 4'b0100);
    beat(32'd57, 0, 1, 4'd7, 1, 4'b0000);
    idle(1, 4'b0000);

    // Avail mismatch: partial avail with a push, then avail without the ctrl strobe.
    step(1'b1, 16'h0001, 32'd40, 1, 1, 4'd1, 1, 4'b0010);
    step(1'b0, 16'hFFFF, 32'd0, 0, 0, 4'd0, 1, 4'b0010);
    idle(1, 4'b0000);

    // Async reset with five beats buffered and an error pulse in flight.
    for (int i = 0; i < 4; i++) beat(32'd60 + 32'(i), 1, 1, 4'd4, 0, 4'b0000);
    step(1'b1, 16'h00FF, 32'd64, 1, 1, 4'd4, 0, 4'b0010);
    chk("pre_rst_fill", fill_level, 5);
    #3 a_rst = 1'b1;
    #1;
    chk("arst_vld", out_vld, 0);
    chk("arst_fill", fill_level, 0);
    chk("arst_err", error, 0);
    q.delete();
    in_ctrl_avail = 1'b0; in_data_avail = '0; out_rdy = 1'b1;
    @(negedge clk) a_rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_vld", out_vld, 0);
    chk("post_rst_fill", fill_level, 0);
    beat(32'd70, 1, 1, 4'd1, 1, 4'b0000);
    idle(1, 4'b0000);
    idle(1, 4'b0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
